bram_uart_loader: RTL

BRAM_UART_LOADER -- requirements
Module: bram_uart_loader

---
 rtl/bram_uart_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bram_uart_loader.sv
// UART boot loader: receives a word-count header and 16-bit words over rx (8N1)
// and writes them to BRAM port B at addresses 0..N-1, holding the CPU until done.
module bram_uart_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] addr_b,
  output logic [15:0] data_b,
  output logic        we_b,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} ld_state_t;

  localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);

  rx_state_t   rx_state_q;
  ld_state_t   ld_state_q;
  logic        rx_meta_q, rx_sync_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        byte_valid_q, frame_err_q;
  logic [7:0]  n_hi_q, word_hi_q;
  logic [15:0] n_q, addr_q;
  logic [15:0] addr_b_q, data_b_q;
  logic        we_b_q, cpu_hold_q, done_q, err_q;
  logic [15:0] n_d, word_d, addr_d;

  // Assembled header, data word and next address from the byte just received.
  always_comb begin
    n_d    = {n_hi_q, shift_q};
    word_d = {word_hi_q, shift_q};
    addr_d = addr_q + 16'd1;
  end

  // UART receiver; the start-bit sample doubles as a glitch filter, and the
  // IDLE detection cycle counts as count 1 so samples land mid-bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            cnt_q      <= 16'd1;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_C) begin
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST_C) begin
            cnt_q   <= 16'd0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_q        <= 16'd0;
            rx_state_q   <= RX_IDLE;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= ~rx_sync_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Load sequencer: header, word assembly, single-cycle write, terminal states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_state_q <= HDR_HI;
      n_hi_q     <= 8'd0;
      word_hi_q  <= 8'd0;
      n_q        <= 16'd0;
      addr_q     <= 16'd0;
      addr_b_q   <= 16'd0;
      data_b_q   <= 16'd0;
      we_b_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_b_q <= 1'b0;
      if (frame_err_q && ld_state_q != DONE && ld_state_q != ERROR) begin
        ld_state_q <= ERROR;
        err_q      <= 1'b1;
      end else begin
        case (ld_state_q)
          HDR_HI: begin
            if (byte_valid_q) begin
              n_hi_q     <= shift_q;
              ld_state_q <= HDR_LO;
            end
          end
          HDR_LO: begin
            if (byte_valid_q) begin
              n_q <= n_d;
              if (n_d == 16'd0) begin
                ld_state_q <= DONE;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else begin
                ld_state_q <= DATA_HI;
              end
            end
          end
          DATA_HI: begin
            if (byte_valid_q) begin
              word_hi_q  <= shift_q;
              ld_state_q <= DATA_LO;
            end
          end
          DATA_LO: begin
            if (byte_valid_q) begin
              ld_state_q <= WRITE;
              we_b_q     <= 1'b1;
              addr_b_q   <= addr_q;
              data_b_q   <= word_d;
            end
          end
          WRITE: begin
            addr_q <= addr_d;
            if (addr_d == n_q) begin
              ld_state_q <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              ld_state_q <= DATA_HI;
            end
          end
          DONE:    ld_state_q <= DONE;
          ERROR:   ld_state_q <= ERROR;
          default: ld_state_q <= HDR_HI;
        endcase
      end
    end
  end

  assign addr_b   = addr_b_q;
  assign data_b   = data_b_q;
  assign we_b     = we_b_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
